// File: rtl/bomber_pkg.sv
// Shared definitions for the key command decoder: HID keycodes, direction
// encoding and the per-player repeat FSM states.
package bomber_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_R     = 8'h15;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} rpt_state_t;

  // A code in both slots still reads as a single held key.
  function automatic logic key_held(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// One player's direction handling: priority encoder, IDLE/DELAY/REPEAT
// auto-repeat FSM and a saturating frame counter. Move and dir are registered.
module key_repeat
  import bomber_pkg::*;
#(
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       move,
  output logic [1:0] dir,
  output logic [1:0] state
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  rpt_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          move_q, move_d;
  dir_t          dir_q, dir_d;
  dir_t          eff_dir;
  logic          any_dir;

  always_comb begin
    any_dir = up | down | left | right;
    eff_dir = RIGHT;
    if (up)        eff_dir = UP;
    else if (down) eff_dir = DOWN;
    else if (left) eff_dir = LEFT;
  end

  // Counter saturates so a stuck count can never alias onto a pulse value.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    move_d  = 1'b0;
    dir_d   = dir_q;
    if (!any_dir) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          move_d  = 1'b1;
          dir_d   = eff_dir;
          cnt_d   = '0;
          state_d = DELAY;
        end
        DELAY, REPEAT: begin
          if (eff_dir != dir_q) begin
            move_d  = 1'b1;
            dir_d   = eff_dir;
            cnt_d   = '0;
            state_d = DELAY;
          end else if (cnt_q == ((state_q == DELAY) ? DLY_LAST : PER_LAST)) begin
            move_d  = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      move_q  <= 1'b0;
      dir_q   <= UP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      dir_q   <= dir_d;
    end
  end

  assign move  = move_q;
  assign dir   = dir_q;
  assign state = state_q;

endmodule

// File: rtl/key_command_decoder.sv
// Decodes two USB HID key slots into per-frame game commands for two players
// plus a start pulse. Bomb and start fire once per press; moves auto-repeat.
module key_command_decoder
  import bomber_pkg::*;
#(
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic        Frame_Clk,
  input  logic        Reset_N,
  input  logic [15:0] Keycode,
  output logic        Move_1,
  output logic [1:0]  Dir_1,
  output logic        Bomb_1,
  output logic        Move_2,
  output logic [1:0]  Dir_2,
  output logic        Bomb_2,
  output logic        Start,
  output logic [1:0]  Fsm_State_1,
  output logic [1:0]  Fsm_State_2
);

  // [0] P1 bomb, [1] P2 bomb, [2] start
  logic [2:0] held_d, held_q;

  assign held_d = {key_held(Keycode, KEY_R),
                   key_held(Keycode, KEY_ENTER),
                   key_held(Keycode, KEY_SPACE)};

  // History clears on reset, so a key held through reset counts as a new press.
  always_ff @(posedge Frame_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      held_q <= '0;
      Bomb_1 <= 1'b0;
      Bomb_2 <= 1'b0;
      Start  <= 1'b0;
    end else begin
      held_q <= held_d;
      Bomb_1 <= held_d[0] & ~held_q[0];
      Bomb_2 <= held_d[1] & ~held_q[1];
      Start  <= held_d[2] & ~held_q[2];
    end
  end

  key_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_p1 (
    .clk   (Frame_Clk),
    .rst_n (Reset_N),
    .up    (key_held(Keycode, KEY_W)),
    .down  (key_held(Keycode, KEY_S)),
    .left  (key_held(Keycode, KEY_A)),
    .right (key_held(Keycode, KEY_D)),
    .move  (Move_1),
    .dir   (Dir_1),
    .state (Fsm_State_1)
  );

  key_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_p2 (
    .clk   (Frame_Clk),
    .rst_n (Reset_N),
    .up    (key_held(Keycode, KEY_UP)),
    .down  (key_held(Keycode, KEY_DOWN)),
    .left  (key_held(Keycode, KEY_LEFT)),
    .right (key_held(Keycode, KEY_RIGHT)),
    .move  (Move_2),
    .dir   (Dir_2),
    .state (Fsm_State_2)
  );

endmodule

// File: tb/tb_key_command_decoder.sv
// Directed bench for key_command_decoder with hand-computed expected outputs.
module tb_key_command_decoder;
  import bomber_pkg::*;

  logic        Frame_Clk;
  logic        Reset_N;
  logic [15:0] Keycode;
  logic        Move_1, Bomb_1, Move_2, Bomb_2, Start;
  logic [1:0]  Dir_1, Dir_2, Fsm_State_1, Fsm_State_2;

  int n_vec = 0;
  int n_bad = 0;

  key_command_decoder #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
    .Frame_Clk   (Frame_Clk),
    .Reset_N     (Reset_N),
    .Keycode     (Keycode),
    .Move_1      (Move_1),
    .Dir_1       (Dir_1),
    .Bomb_1      (Bomb_1),
    .Move_2      (Move_2),
    .Dir_2       (Dir_2),
    .Bomb_2      (Bomb_2),
    .Start       (Start),
    .Fsm_State_1 (Fsm_State_1),
    .Fsm_State_2 (Fsm_State_2)
  );

  // clock / reset
  initial Frame_Clk = 1'b0;
  always #5 Frame_Clk = ~Frame_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the edge, inputs changed there too.
  task automatic step();
    @(posedge Frame_Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic m1, input logic [1:0] d1, input logic b1,
                         input logic m2, input logic [1:0] d2, input logic b2, input logic st);
    check({tag, ".move_1"}, Move_1, m1);
    check({tag, ".dir_1"},  Dir_1,  d1);
    check({tag, ".bomb_1"}, Bomb_1, b1);
    check({tag, ".move_2"}, Move_2, m2);
    check({tag, ".dir_2"},  Dir_2,  d2);
    check({tag, ".bomb_2"}, Bomb_2, b2);
    check({tag, ".start"},  Start,  st);
  endtask

  task automatic idle_frame(input string tag);
    Keycode = 16'h0000;
    step();
    check({tag, ".idle_m1"}, Move_1, 1'b0);
    check({tag, ".idle_st1"}, Fsm_State_1, IDLE);
  endtask

  initial begin
    Reset_N = 1'b0;
    Keycode = 16'h0000;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.st1", Fsm_State_1, IDLE);
    check("reset.st2", Fsm_State_2, IDLE);

    // Start pulses once, not while held
    Reset_N = 1'b1;
    step();
    Keycode = 16'h0015;
    step();
    chk_out("start", 0, 0, 0, 0, 0, 0, 1);
    step();
    check("start_held", Start, 1'b0);
    Keycode = 16'h0000;
    step();
    check("start_rel", Start, 1'b0);

    // P1 right held 20 frames: pulses at 1, 9, 13, 17
    Keycode = 16'h0007;
    for (int f = 1; f <= 20; f++) begin
      step();
      check($sformatf("rpt_f%0d.move_1", f), Move_1, (f == 1 || f == 9 || f == 13 || f == 17));
      check($sformatf("rpt_f%0d.dir_1", f), Dir_1, 2'd3);
      check($sformatf("rpt_f%0d.move_2", f), Move_2, 1'b0);
    end
    check("rpt.state", Fsm_State_1, REPEAT);
    idle_frame("rpt_rel");
    check("rpt_rel.dir_hold", Dir_1, 2'd3);

    // both players in one frame
    Keycode = 16'h5207;
    step();
    chk_out("both", 1, 3, 0, 1, 0, 0, 0);
    idle_frame("both_rel");

    // W+D gives up; dropping W gives immediate right and delay restart
    Keycode = 16'h1A07;
    step();
    check("wd.move_1", Move_1, 1'b1);
    check("wd.dir_1", Dir_1, 2'd0);
    for (int f = 0; f < 3; f++) begin
      step();
      check("wd_hold.move_1", Move_1, 1'b0);
    end
    Keycode = 16'h0007;
    step();
    check("chg.move_1", Move_1, 1'b1);
    check("chg.dir_1", Dir_1, 2'd3);
    check("chg.state", Fsm_State_1, DELAY);
    for (int f = 1; f <= 8; f++) begin
      step();
      check($sformatf("chg_f%0d.move_1", f), Move_1, (f == 8));
    end
    idle_frame("chg_rel");

    // bomb: one pulse over 10 frames, then same code in both slots
    Keycode = 16'h002C;
    for (int f = 1; f <= 10; f++) begin
      step();
      check($sformatf("bomb_f%0d", f), Bomb_1, (f == 1));
    end
    Keycode = 16'h2C2C;
    for (int f = 0; f < 3; f++) begin
      step();
      check("bomb_dup", Bomb_1, 1'b0);
    end
    Keycode = 16'h0000;
    step();
    // bomb and move together
    Keycode = 16'h2C1A;
    step();
    chk_out("bomb_move", 1, 0, 1, 0, 0, 0, 0);
    idle_frame("bomb_move_rel");

    // P1 priority: down over left, then left over right
    Keycode = 16'h0416;
    step();
    check("pri_ds.move_1", Move_1, 1'b1);
    check("pri_ds.dir_1", Dir_1, 2'd1);
    Keycode = 16'h0407;
    step();
    check("pri_lr.move_1", Move_1, 1'b1);
    check("pri_lr.dir_1", Dir_1, 2'd2);
    idle_frame("pri_rel");
    check("pri_rel.dir_hold", Dir_1, 2'd2);

    // P2: down over left, then enter gives bomb without extra move
    Keycode = 16'h5051;
    step();
    chk_out("p2_down", 0, 2, 0, 1, 1, 0, 0);
    Keycode = 16'h2851;
    step();
    chk_out("p2_bomb", 0, 2, 0, 0, 1, 1, 0);
    step();
    check("p2_bomb_held", Bomb_2, 1'b0);
    Keycode = 16'h0000;
    step();
    check("p2_rel.st2", Fsm_State_2, IDLE);

    // reset mid-hold: abort at once, re-press after release
    Keycode = 16'h0016;
    step();
    check("rst_pre.move_1", Move_1, 1'b1);
    check("rst_pre.dir_1", Dir_1, 2'd1);
    step();
    step();
    Reset_N = 1'b0;
    #1;
    chk_out("rst_async", 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("rst_hold1", 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("rst_hold2", 0, 0, 0, 0, 0, 0, 0);
    Reset_N = 1'b1;
    step();
    check("rst_post.move_1", Move_1, 1'b1);
    check("rst_post.dir_1", Dir_1, 2'd1);
    for (int f = 1; f <= 8; f++) begin
      step();
      check($sformatf("rst_post_f%0d.move_1", f), Move_1, (f == 8));
    end
    idle_frame("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_command_decoder.md
KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

Interface
REQ-001 Parameter REPEAT_DELAY, default 8: frames a direction must be held after its first pulse before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 4: frames between auto-repeat pulses once repeating.
REQ-003 Frame_Clk  input  1  single clock, one tick per video frame; all state on its rising edge.
REQ-004 Reset_N  input  1  asynchronous, active-low reset.
REQ-005 Keycode  input  16  two USB HID key slots, [7:0] slot A and [15:8] slot B; 8'h00 = empty.
REQ-006 Move_1  output  1  one-frame pulse: player 1 moves one step in Dir_1.
REQ-007 Dir_1  output  2  player 1 direction: 0 up, 1 down, 2 left, 3 right.
REQ-008 Bomb_1  output  1  one-frame pulse: player 1 drops a bomb.
REQ-009 Move_2, Dir_2, Bomb_2  output  1/2/1  same meaning for player 2.
REQ-010 Start  output  1  one-frame pulse: start or restart the game.

Function
REQ-011 Key map: P1 up 8'h1A (W), down 8'h16 (S), left 8'h04 (A), right 8'h07 (D), bomb 8'h2C (space); P2 up 8'h52, down 8'h51, left 8'h50, right 8'h4F, bomb 8'h28 (enter); Start 8'h15 (R); all other codes are ignored.
REQ-012 A key counts as held when either slot equals its code; the same code in both slots counts as one key.
REQ-013 Per player, the effective direction is the held direction key of highest priority: up > down > left > right; none held = no direction.
REQ-014 All outputs are registered: an input condition sampled at edge n drives its output from edge n+1 for exactly one frame.
REQ-015 Per-player FSM states: IDLE, DELAY, REPEAT.
REQ-016 IDLE, effective direction appears: pulse Move, load Dir, clear counter, go to DELAY.
REQ-017 DELAY: counter increments each frame; at REPEAT_DELAY frames after the first pulse, pulse Move, clear counter, go to REPEAT.
REQ-018 REPEAT: pulse Move every REPEAT_PERIOD frames with the same Dir.
REQ-019 In DELAY or REPEAT, a change of effective direction gives an immediate pulse with the new Dir, clears the counter and goes to DELAY.
REQ-020 In any state, no direction held: go to IDLE, clear counter, no pulse.
REQ-021 Dir holds its last value between pulses and while IDLE.
REQ-022 Bomb_x and Start pulse only on a rising edge of key-held (not held last frame, held now); no auto-repeat.
REQ-023 P1 and P2 decode independently; simultaneous events for both players, or a Move and a Bomb for one player, all pulse in the same frame.
REQ-024 The counter is wide enough for max(REPEAT_DELAY, REPEAT_PERIOD) and saturates; it never wraps into a spurious pulse.

Reset
REQ-025 While Reset_N = 0: all pulse outputs 0, Dir_1 = Dir_2 = 0 (up), both FSMs IDLE, counters 0, key-held history registers 0.
REQ-026 A key held across reset release is treated as a new press: it gives one pulse in the frame after the first edge with Reset_N = 1.
REQ-027 Reset asserted mid-repeat aborts immediately; no pulse is emitted in the frame of assertion.

Structure
REQ-028 Package bomber_pkg holds the keycode localparams, the dir_t 2-bit enum (UP, DOWN, LEFT, RIGHT) and the repeat FSM state enum.
REQ-029 Sub-module key_repeat holds one player's priority encoder, FSM and counter.
REQ-030 The top level instantiates key_repeat twice and holds the slot matching and the rising-edge detectors for bomb and start.

Verification
REQ-031 Reset_N 0 then 1, Keycode 16'h0015 for one frame -> Start = 1 for exactly one frame, all other outputs 0.
REQ-032 Keycode 16'h0007 held 20 frames (defaults) -> Move_1 pulses at frames 1, 9, 13, 17 relative to the press, Dir_1 = 3 throughout; Move_2 stays 0.
REQ-033 Keycode 16'h5207 held, i.e. D and P2 up together -> Move_1 with Dir_1 = 3 and Move_2 with Dir_2 = 0 in the same frame.
REQ-034 Keycode 16'h1A07 (W + D) -> Dir_1 = 0; change to 16'h0007 while held -> immediate Move_1 with Dir_1 = 3, delay restarts.
REQ-035 Keycode 16'h002C held 10 frames, then 16'h2C2C -> exactly one Bomb_1 pulse.
REQ-036 16'h0016 held, Reset_N pulsed low for 2 frames -> outputs 0 during reset, one Move_1 with Dir_1 = 1 on the frame after release, then repeat timing restarts.
